multi_fan_pwm: RTL and testbench

MULTI_FAN_PWM -- requirements
Module: multi_fan_pwm

---
 rtl/multi_fan_pwm_if.sv | 23 ++
 rtl/multi_fan_pwm.sv | 95 +++++++++
 tb/tb_multi_fan_pwm.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_fan_pwm_if.sv
// Control/status bundle for multi_fan_pwm: target speeds and strobes in,
// per-channel PWM pins and status out.
interface multi_fan_pwm_if #(
  parameter int NCH = 2,
  parameter int W   = 8
);
  logic [NCH*W-1:0] speed;
  logic             load;
  logic             force_full;
  logic [NCH-1:0]   pwm_out;
  logic [NCH-1:0]   at_target;
  logic             period_start;

  modport master (
    output speed, load, force_full,
    input  pwm_out, at_target, period_start
  );

  modport slave (
    input  speed, load, force_full,
    output pwm_out, at_target, period_start
  );
endinterface

// File: rtl/multi_fan_pwm.sv
// NCH-channel fan PWM whose duty only changes on period boundaries.
// Define FAN_RAMP_EN for a slew-limited ramp (one LSB every RAMP_DIV periods); otherwise duty jumps to target.
module multi_fan_pwm #(
  parameter int NCH      = 2,
  parameter int W        = 8,
  parameter int RAMP_DIV = 4
) (
  input  logic           clk,
  input  logic           arst,
  multi_fan_pwm_if.slave bus
);

  if (NCH < 1 || NCH > 8 || W < 4 || W > 12 || RAMP_DIV < 1 || RAMP_DIV > 255) begin : g_bad_param
    $error("multi_fan_pwm: parameter out of range");
  end

  logic [W-1:0]   cnt;
  logic [W-1:0]   cnt_next;
  logic           boundary;
  logic [W-1:0]   tgt      [NCH];
  logic [W-1:0]   cur      [NCH];
  logic [W-1:0]   cur_next [NCH];
  logic [NCH-1:0] pwm;
  logic           period_start;

  assign cnt_next = cnt + 1'b1;
  assign boundary = (cnt_next == '0);

`ifdef FAN_RAMP_EN
  logic [7:0] pre;
  logic       step;

  assign step = boundary && (pre == 8'(RAMP_DIV - 1));

  // Prescaler restarts from zero after reset, so an aborted ramp never resumes mid-count.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      pre <= '0;
    end else if (boundary) begin
      pre <= step ? '0 : pre + 8'd1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cur_next[i] = cur[i];
      if (step) begin
        if (cur[i] < tgt[i])      cur_next[i] = cur[i] + 1'b1;
        else if (cur[i] > tgt[i]) cur_next[i] = cur[i] - 1'b1;
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cur_next[i] = boundary ? tgt[i] : cur[i];
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values;
  // this is also what makes a load on a boundary edge act only at the following boundary.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt          <= '0;
      period_start <= 1'b0;
      pwm          <= '0;
      // NOTE: the tgt/cur arrays are reset explicitly; at_target must read all ones straight out of reset.
      for (int i = 0; i < NCH; i++) begin
        tgt[i] <= '0;
        cur[i] <= '0;
      end
    end else begin
      cnt          <= cnt_next;
      period_start <= boundary;
      for (int i = 0; i < NCH; i++) begin
        cur[i] <= cur_next[i];
        if (bus.load) tgt[i] <= bus.speed[i*W +: W];
        pwm[i] <= bus.force_full | (cnt_next < cur_next[i]);
      end
    end
  end

  always_comb begin
    bus.at_target = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.at_target[i] = (cur[i] == tgt[i]);
    end
  end

  assign bus.pwm_out      = pwm;
  assign bus.period_start = period_start;

endmodule

// File: tb/tb_multi_fan_pwm.sv
// Self-checking bench for multi_fan_pwm: per-cycle comparison against a period/boundary-level model,
// directed scenarios with literal duty counts, and a randomized load/override phase.
module tb_multi_fan_pwm;
  localparam int NCH    = 2;
  localparam int W      = 8;
  localparam int RD     = 4;
  localparam int PERIOD = 1 << W;

  logic clk = 1'b0;
  logic arst;
  int   tests = 0;
  int   fails = 0;
  bit   run_cmp = 1'b0;

  multi_fan_pwm_if #(.NCH(NCH), .W(W)) bus ();

  multi_fan_pwm #(.NCH(NCH), .W(W), .RAMP_DIV(RD)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: t counts clock edges since reset, so the counter is t mod PERIOD and
  // boundary k happens at t = k*PERIOD; ramp steps fall on every RD-th boundary.
  int             t;
  int             m_tgt [NCH];
  int             m_cur [NCH];
  logic [NCH-1:0] exp_pwm;
  logic           exp_ps;

  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      t = 0;
      for (int i = 0; i < NCH; i++) begin
        m_tgt[i] = 0;
        m_cur[i] = 0;
      end
      exp_pwm = '0;
      exp_ps  = 1'b0;
    end else begin
      t++;
      if (t % PERIOD == 0) begin
`ifdef FAN_RAMP_EN
        if ((t / PERIOD) % RD == 0)
          for (int i = 0; i < NCH; i++)
            m_cur[i] += (m_cur[i] < m_tgt[i]) ? 1 : (m_cur[i] > m_tgt[i]) ? -1 : 0;
`else
        for (int i = 0; i < NCH; i++) m_cur[i] = m_tgt[i];
`endif
      end
      if (bus.load)
        for (int i = 0; i < NCH; i++) m_tgt[i] = int'(bus.speed[i*W +: W]);
      for (int i = 0; i < NCH; i++)
        exp_pwm[i] = bus.force_full || ((t % PERIOD) < m_cur[i]);
      exp_ps = ((t % PERIOD) == 0);
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      logic [NCH-1:0] exp_at;
      for (int i = 0; i < NCH; i++) exp_at[i] = (m_cur[i] == m_tgt[i]);
      check("cyc_pwm_out", 32'(bus.pwm_out), 32'(exp_pwm));
      check("cyc_at_target", 32'(bus.at_target), 32'(exp_at));
      check("cyc_period_start", 32'(bus.period_start), 32'(exp_ps));
    end
  end

  task automatic load_speed(input logic [NCH*W-1:0] v);
    @(negedge clk);
    bus.speed = v;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  // Returns at the negedge where period_start is high (counter = 0).
  task automatic wait_boundary(input string name);
    bit found = 1'b0;
    for (int k = 0; k < PERIOD + 8 && !found; k++) begin
      if (bus.period_start === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) check({name, "_boundary_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_target(input string name, input int max_periods);
    bit ok = 1'b0;
    for (int p = 0; p < max_periods && !ok; p++) begin
      wait_boundary(name);
      if (bus.at_target === '1) ok = 1'b1;
      else @(negedge clk);
    end
    check({name, "_reached"}, 32'(ok), 32'd1);
  endtask

  // Counts high cycles per channel and period_start pulses over one full period from a boundary.
  task automatic measure(input string name, output int h0, output int h1, output int nps);
    h0 = 0; h1 = 0; nps = 0;
    wait_boundary(name);
    for (int k = 0; k < PERIOD; k++) begin
      h0  += int'(bus.pwm_out[0]);
      h1  += int'(bus.pwm_out[1]);
      nps += int'(bus.period_start);
      @(negedge clk);
    end
  endtask

  initial begin
    int h0, h1, nps, nforce;
    arst           = 1'b0;
    bus.speed      = '0;
    bus.load       = 1'b0;
    bus.force_full = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pwm_out", 32'(bus.pwm_out), 32'd0);
    check("reset_period_start", 32'(bus.period_start), 32'd0);
    check("reset_at_target", 32'(bus.at_target), 32'h3);
    arst    = 1'b1;
    run_cmp = 1'b1;
    @(negedge clk);
    check("first_edge_no_period_start", 32'(bus.period_start), 32'd0);

    // ch1 ramps to 0x08, ch0 stays at zero duty
    load_speed(16'h0800);
    wait_target("ramp_ch1", 8 * RD + 4);
    measure("ramp_ch1", h0, h1, nps);
    check("ch1_duty_08", 32'(h1), 32'd8);
    check("ch0_stays_low", 32'(h0), 32'd0);
    check("one_period_start_per_period", 32'(nps), 32'd1);

    load_speed(16'h0810);
    wait_target("ramp_ch0", 16 * RD + 4);
    measure("ramp_ch0", h0, h1, nps);
    check("ch0_duty_10", 32'(h0), 32'd16);

    // downward ramp by two LSBs
    load_speed(16'h080E);
    wait_target("ramp_down", 2 * RD + 4);
    measure("ramp_down", h0, h1, nps);
    check("ch0_duty_0e", 32'(h0), 32'd14);
    check("ch1_duty_unchanged", 32'(h1), 32'd8);

    // load just before a wrap: current period untouched (model), next period per mode
    wait_boundary("late_load");
    repeat (PERIOD - 3) @(negedge clk);
    bus.speed = 16'h0880;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    measure("late_load", h0, h1, nps);
`ifdef FAN_RAMP_EN
    check("late_load_ramp_duty", 32'(h0 == 14 || h0 == 15), 32'd1);
`else
    check("late_load_jump_duty", 32'(h0), 32'd128);
`endif

    // randomized loads and override pulses, checked cycle by cycle against the model
    for (int r = 0; r < 14; r++) begin
      repeat ($urandom_range(600, 1)) @(negedge clk);
      if ($urandom_range(1, 0) == 0) begin
        load_speed(16'($urandom));
      end else begin
        bus.force_full = 1'b1;
        repeat ($urandom_range(40, 1)) @(negedge clk);
        bus.force_full = 1'b0;
      end
    end

    // sustained override: all outputs high regardless of counter
    load_speed(16'h0820);
    nforce = 0;
    @(negedge clk);
    bus.force_full = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (bus.pwm_out === 2'b11) nforce++;
    end
    bus.force_full = 1'b0;
    check("force_full_all_high", 32'(nforce), 32'd300);
    repeat (2 * PERIOD) @(negedge clk);

    // full-scale duty on ch1
    load_speed(16'hFF00);
`ifndef FAN_RAMP_EN
    wait_boundary("full_scale");
    @(negedge clk);
    measure("full_scale", h0, h1, nps);
    check("ch1_duty_ff", 32'(h1), 32'd255);
    check("ch0_duty_zero", 32'(h0), 32'd0);
    check("full_scale_period_start", 32'(nps), 32'd1);
`else
    repeat (3 * PERIOD) @(negedge clk);
`endif

    // asynchronous reset in the middle of a period
    wait_boundary("mid_reset");
    repeat (100) @(negedge clk);
    @(posedge clk);
    #3;
    arst = 1'b0;
    #1;
    check("async_reset_pwm_out", 32'(bus.pwm_out), 32'd0);
    check("async_reset_period_start", 32'(bus.period_start), 32'd0);
    check("async_reset_at_target", 32'(bus.at_target), 32'h3);
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    check("post_reset_at_target", 32'(bus.at_target), 32'h3);
    check("post_reset_pwm_out", 32'(bus.pwm_out), 32'd0);
    measure("post_reset", h0, h1, nps);
    check("post_reset_duty_zero", 32'(h0 + h1), 32'd0);

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
